// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with request/ack memory handshake, one-entry stall buffer and IF/ID register
`ifndef IWIDTH
`define IWIDTH 32
`endif
module fetch_stage #(
    parameter logic [`IWIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              f_i_clk,
    input  logic              f_i_rst,
    input  logic              f_i_stall,
    input  logic              f_i_flush,
    input  logic              f_i_redirect,
    input  logic [`IWIDTH-1:0] f_i_redirect_pc,
    output logic              f_o_imem_req,
    output logic [`IWIDTH-1:0] f_o_imem_addr,
    input  logic              f_i_imem_ack,
    input  logic [`IWIDTH-1:0] f_i_imem_rdata,
    output logic [`IWIDTH-1:0] f_o_instr,
    output logic [`IWIDTH-1:0] f_o_pc,
    output logic [`IWIDTH-1:0] f_o_pc_next,
    output logic              f_o_ce
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;
    state_t state, state_nx;
    logic [`IWIDTH-1:0] pc, drop_addr, buf_instr, buf_pc, target;
    logic load_req, load_hold, ack_req;
    assign target = {f_i_redirect_pc[`IWIDTH-1:2], 2'b00};
    assign ack_req = state == REQ && f_i_imem_ack;
    assign load_req = ack_req && !f_i_redirect && !f_i_stall;
    assign load_hold = state == HOLD && !f_i_redirect && !f_i_stall;
    assign f_o_imem_req = state == REQ || state == DROP;
    // a request abandoned by redirect keeps its address until the memory answers
    assign f_o_imem_addr = state == DROP ? drop_addr : pc;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = REQ;
            REQ:  state_nx = f_i_imem_ack ? ((!f_i_redirect && f_i_stall) ? HOLD : REQ)
                                          : (f_i_redirect ? DROP : REQ);
            HOLD: state_nx = (f_i_redirect || !f_i_stall) ? REQ : HOLD;
            DROP: state_nx = f_i_imem_ack ? REQ : DROP;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge f_i_clk) state <= f_i_rst ? IDLE : state_nx;
    always_ff @(posedge f_i_clk) begin
        if (f_i_rst) begin
            pc <= RESET_PC;
            drop_addr <= '0;
            buf_instr <= '0;
            buf_pc <= '0;
            f_o_instr <= '0;
            f_o_pc <= '0;
            f_o_pc_next <= '0;
            f_o_ce <= 1'b0;
        end else begin
            if (f_i_redirect) pc <= target;
            else if (ack_req) pc <= pc + 4;
            if (state == REQ && !f_i_imem_ack && f_i_redirect) drop_addr <= pc;
            if (ack_req && !f_i_redirect && f_i_stall) begin
                buf_instr <= f_i_imem_rdata;
                buf_pc <= pc;
            end
            if (f_i_flush) begin
                f_o_instr <= '0;
                f_o_pc <= '0;
                f_o_pc_next <= '0;
                f_o_ce <= 1'b0;
            end else if (f_i_stall) begin
                f_o_ce <= f_o_ce;
            end else if (load_req) begin
                f_o_instr <= f_i_imem_rdata;
                f_o_pc <= pc;
                f_o_pc_next <= pc + 4;
                f_o_ce <= 1'b1;
            end else if (load_hold) begin
                f_o_instr <= buf_instr;
                f_o_pc <= buf_pc;
                f_o_pc_next <= buf_pc + 4;
                f_o_ce <= 1'b1;
            end else begin
                f_o_ce <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage handshake, stall, redirect, flush and reset behaviour
module tb_fetch_stage;
    logic clk = 1'b0, rst = 1'b1, stall = 1'b0, flush = 1'b0, redirect = 1'b0, ack = 1'b0, sel = 1'b0;
    logic [31:0] redirect_pc = '0, rdata;
    logic req0, ce0, req1, ce1;
    logic [31:0] addr0, instr0, pc0, pcn0, addr1, instr1, pc1, pcn1;
    int pass_cnt = 0, total = 0;
    always #5 clk = ~clk;
    assign rdata = sel ? addr1 : addr0;
    fetch_stage u0 (
        .f_i_clk(clk), .f_i_rst(rst), .f_i_stall(stall), .f_i_flush(flush),
        .f_i_redirect(redirect), .f_i_redirect_pc(redirect_pc),
        .f_o_imem_req(req0), .f_o_imem_addr(addr0), .f_i_imem_ack(ack), .f_i_imem_rdata(rdata),
        .f_o_instr(instr0), .f_o_pc(pc0), .f_o_pc_next(pcn0), .f_o_ce(ce0)
    );
    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u1 (
        .f_i_clk(clk), .f_i_rst(rst), .f_i_stall(stall), .f_i_flush(flush),
        .f_i_redirect(redirect), .f_i_redirect_pc(redirect_pc),
        .f_o_imem_req(req1), .f_o_imem_addr(addr1), .f_i_imem_ack(ack), .f_i_imem_rdata(rdata),
        .f_o_instr(instr1), .f_o_pc(pc1), .f_o_pc_next(pcn1), .f_o_ce(ce1)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset;
        rst = 1'b1; ack = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
        tick;
        tick;
        rst = 1'b0;
    endtask
    initial begin
        do_reset;
        chk("rst_ce", 32'(ce0), 0);
        chk("rst_req", 32'(req0), 0);
        chk("rst_pc", pc0, 0);
        chk("rst_instr", instr0, 0);
        chk("rst_pcn", pcn0, 0);
        ack = 1'b1;
        tick;
        chk("s1_req", 32'(req0), 1);
        chk("s1_addr", addr0, 0);
        chk("s1_ce", 32'(ce0), 0);
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("seq_ce", 32'(ce0), 1);
            chk("seq_pc", pc0, 32'(4 * i));
            chk("seq_instr", instr0, 32'(4 * i));
            chk("seq_pcn", pcn0, 32'(4 * i + 4));
        end
        do_reset;
        tick;
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < 3; c++) begin
                ack = (c == 2);
                chk("lat_addr", addr0, 32'(4 * k));
                chk("lat_req", 32'(req0), 1);
                tick;
                chk("lat_ce", 32'(ce0), 32'(c == 2));
                if (c == 2) chk("lat_pc", pc0, 32'(4 * k));
            end
        do_reset;
        ack = 1'b1;
        tick;
        tick;
        tick;
        chk("st_pre", pc0, 4);
        stall = 1'b1;
        tick;
        chk("st_hold1", pc0, 4);
        chk("st_req", 32'(req0), 0);
        tick;
        chk("st_hold2", pc0, 4);
        stall = 1'b0;
        tick;
        chk("st_pc8", pc0, 8);
        chk("st_instr8", instr0, 8);
        chk("st_ce8", 32'(ce0), 1);
        tick;
        chk("st_pc12", pc0, 12);
        do_reset;
        ack = 1'b1;
        tick;
        for (int i = 0; i < 4; i++) tick;
        chk("rd_pre", pc0, 12);
        ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h40;
        tick;
        chk("rd_drop_addr", addr0, 32'h10);
        chk("rd_drop_req", 32'(req0), 1);
        chk("rd_drop_ce", 32'(ce0), 0);
        redirect = 1'b0; ack = 1'b1;
        tick;
        chk("rd_disc_ce", 32'(ce0), 0);
        chk("rd_no10", 32'(pc0 == 32'h10), 0);
        chk("rd_addr40", addr0, 32'h40);
        tick;
        chk("rd_pc40", pc0, 32'h40);
        chk("rd_instr40", instr0, 32'h40);
        chk("rd_ce40", 32'(ce0), 1);
        do_reset;
        ack = 1'b1;
        tick;
        tick;
        tick;
        flush = 1'b1; redirect = 1'b1; redirect_pc = 32'h43;
        tick;
        chk("fl_ce", 32'(ce0), 0);
        chk("fl_instr", instr0, 0);
        chk("fl_pc", pc0, 0);
        flush = 1'b0; redirect = 1'b0;
        tick;
        chk("fl_pc40", pc0, 32'h40);
        chk("fl_ce40", 32'(ce0), 1);
        sel = 1'b1;
        do_reset;
        ack = 1'b1;
        tick;
        chk("wr_addr", addr1, 32'hFFFF_FFFC);
        tick;
        chk("wr_pc", pc1, 32'hFFFF_FFFC);
        chk("wr_pcn", pcn1, 0);
        chk("wr_ce", 32'(ce1), 1);
        tick;
        chk("wr_pc0", pc1, 0);
        chk("wr_instr0", instr1, 0);
        sel = 1'b0;
        do_reset;
        tick;
        redirect = 1'b1; redirect_pc = 32'h80;
        tick;
        chk("dr_req", 32'(req0), 1);
        rst = 1'b1; redirect = 1'b0; ack = 1'b1;
        tick;
        chk("dr_rst_req", 32'(req0), 0);
        chk("dr_rst_ce", 32'(ce0), 0);
        chk("dr_rst_pc", pc0, 0);
        chk("dr_rst_instr", instr0, 0);
        chk("dr_rst_addr", addr0, 0);
        rst = 1'b0;
        tick;
        chk("dr_idle_ack", 32'(ce0), 0);
        tick;
        chk("dr_first_ce", 32'(ce0), 1);
        chk("dr_first_pc", pc0, 0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
